text_console_writer: RTL and testbench

- Upstream feeder for the text display memory. Accepts an ASCII byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Tracks a cursor over the 100x75 character grid and converts bytes into write_data/write_address/write_enable cycles for text memory.
- Handles control codes: carriage return, line feed, backspace and form feed. Line feed and form feed run multi-cycle clear sweeps.

---
 rtl/text_pkg.sv | 24 ++
 rtl/text_cursor_counter.sv | 68 ++++++
 rtl/text_console_writer.sv | 159 +++++++++++++++
 tb/tb_text_console_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants for the text console: display geometry, ASCII control codes
// and the writer state encoding.
package text_pkg;
   localparam int H_DISPLAY       = 800;
   localparam int V_DISPLAY       = 600;
   localparam int FONT_W          = 8;
   localparam int FONT_H          = 8;
   localparam int COLUMNS         = H_DISPLAY / FONT_W;
   localparam int ROWS            = V_DISPLAY / FONT_H;
   localparam int TEXT_MEM_LENGTH = COLUMNS * ROWS;
   localparam int ADDR_W          = 13;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_FF    = 8'h0C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {
      S_READY,
      S_CLR_LINE,
      S_CLR_SCREEN
   } writer_state_e;
endpackage

// File: rtl/text_cursor_counter.sv
// Cursor position over the character grid; row_base tracks row*COLUMNS so the
// cell address needs only an adder.
module text_cursor_counter #(
   parameter int COLUMNS = text_pkg::COLUMNS,
   parameter int ROWS    = text_pkg::ROWS,
   parameter int ADDR_W  = text_pkg::ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inc_col,
   input  logic              dec_col,
   input  logic              new_line,
   input  logic              carriage_return,
   input  logic              home,
   output logic [6:0]        col,
   output logic [6:0]        row,
   output logic [ADDR_W-1:0] addr,
   output logic              col_wrap
);
   logic [6:0]        col_q, col_d, row_q, row_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              row_last;

   assign col_wrap = (col_q == 7'(COLUMNS - 1));
   assign row_last = (row_q == 7'(ROWS - 1));

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
      if (home) begin
         col_d  = '0;
         row_d  = '0;
         base_d = '0;
      end else if (new_line || (inc_col && col_wrap)) begin
         col_d = '0;
         if (row_last) begin
            row_d  = '0;
            base_d = '0;
         end else begin
            row_d  = row_q + 7'd1;
            base_d = base_q + ADDR_W'(COLUMNS);
         end
      end else if (inc_col) begin
         col_d = col_q + 7'd1;
      end else if (dec_col && (col_q != 7'd0)) begin
         col_d = col_q - 7'd1;
      end else if (carriage_return) begin
         col_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         col_q  <= '0;
         row_q  <= '0;
         base_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         base_q <= base_d;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign addr = base_q + ADDR_W'(col_q);
endmodule

// File: rtl/text_console_writer.sv
// Turns an ASCII byte stream into text-memory write strobes.
// state        | meaning
// S_READY      | accepting bytes, one per cycle
// S_CLR_LINE   | writing FILL_CHAR across the cursor row, input stalled
// S_CLR_SCREEN | writing FILL_CHAR to every cell, input stalled
module text_console_writer
   import text_pkg::*;
#(
   parameter int         COLUMNS          = text_pkg::COLUMNS,
   parameter int         ROWS             = text_pkg::ROWS,
   parameter int         ADDR_W           = text_pkg::ADDR_W,
   parameter logic [7:0] FILL_CHAR        = 8'h20,
   parameter bit         CLEAR_ON_NEWLINE = 1'b1,
   parameter bit         CLEAR_ON_RESET   = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        write_data,
   output logic [ADDR_W-1:0] write_address,
   output logic              write_enable,
   output logic [6:0]        cursor_col,
   output logic [6:0]        cursor_row,
   output logic              busy
);
   localparam logic [ADDR_W-1:0] LINE_LAST   = ADDR_W'(COLUMNS - 1);
   localparam logic [ADDR_W-1:0] SCREEN_LAST = ADDR_W'(COLUMNS * ROWS - 1);

   writer_state_e     state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, waddr_q, waddr_d, cur_addr;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d, ready_q, busy_q, init_q;
   logic              inc_col, dec_col, new_line, carriage_return, home, col_wrap;
   logic              accept, printable;

   text_cursor_counter #(
      .COLUMNS (COLUMNS),
      .ROWS    (ROWS),
      .ADDR_W  (ADDR_W)
   ) u_cursor (
      .clock           (clock),
      .reset           (reset),
      .inc_col         (inc_col),
      .dec_col         (dec_col),
      .new_line        (new_line),
      .carriage_return (carriage_return),
      .home            (home),
      .col             (cursor_col),
      .row             (cursor_row),
      .addr            (cur_addr),
      .col_wrap        (col_wrap)
   );

   assign accept    = in_valid & ready_q;
   assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      we_d            = 1'b0;
      wdata_d         = wdata_q;
      waddr_d         = waddr_q;
      inc_col         = 1'b0;
      dec_col         = 1'b0;
      new_line        = 1'b0;
      carriage_return = 1'b0;
      home            = 1'b0;
      case (state_q)
         S_READY: begin
            if (init_q) begin
               state_d = S_CLR_SCREEN;
               cnt_d   = '0;
            end else if (accept) begin
               if (printable) begin
                  we_d    = 1'b1;
                  wdata_d = in_data;
                  waddr_d = cur_addr;
                  inc_col = 1'b1;
                  if (col_wrap && CLEAR_ON_NEWLINE) begin
                     state_d = S_CLR_LINE;
                     cnt_d   = '0;
                  end
               end else begin
                  case (in_data)
                     ASCII_CR: carriage_return = 1'b1;
                     ASCII_LF: begin
                        new_line = 1'b1;
                        if (CLEAR_ON_NEWLINE) begin
                           state_d = S_CLR_LINE;
                           cnt_d   = '0;
                        end
                     end
                     ASCII_BS: begin
                        if (cursor_col != 7'd0) begin
                           dec_col = 1'b1;
                           we_d    = 1'b1;
                           wdata_d = FILL_CHAR;
                           waddr_d = cur_addr - ADDR_W'(1);
                        end
                     end
                     ASCII_FF: begin
                        home    = 1'b1;
                        state_d = S_CLR_SCREEN;
                        cnt_d   = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_CLR_LINE: begin
            // cursor sits at column 0 here, so cur_addr is the row base
            we_d    = 1'b1;
            wdata_d = FILL_CHAR;
            waddr_d = cur_addr + cnt_q;
            if (cnt_q == LINE_LAST) state_d = S_READY;
            else                    cnt_d   = cnt_q + ADDR_W'(1);
         end
         S_CLR_SCREEN: begin
            we_d    = 1'b1;
            wdata_d = FILL_CHAR;
            waddr_d = cnt_q;
            if (cnt_q == SCREEN_LAST) state_d = S_READY;
            else                      cnt_d   = cnt_q + ADDR_W'(1);
         end
         default: state_d = S_READY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_READY;
         cnt_q   <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         init_q  <= CLEAR_ON_RESET;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         ready_q <= (state_d == S_READY);
         busy_q  <= (state_d != S_READY);
         init_q  <= 1'b0;
      end
   end

   assign in_ready      = ready_q;
   assign busy          = busy_q;
   assign write_enable  = we_q;
   assign write_data    = wdata_q;
   assign write_address = waddr_q;
endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a grid-level model queues expected
// writes, a negedge monitor pops them as the DUT strobes.
module tb_text_console_writer;
   localparam int COLS   = 100;
   localparam int NROWS  = 75;
   localparam int SCREEN = COLS * NROWS;
   localparam int LIM    = 20000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  write_data;
   logic [12:0] write_address;
   logic        write_enable;
   logic [6:0]  cursor_col, cursor_row;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int exp_addr_q[$];
   int exp_data_q[$];
   int m_col = 0;
   int m_row = 0;
   int last_wait = 0;
   int mon_a, mon_d;

   always #5 clock = ~clock;

   text_console_writer dut (
      .clock         (clock),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .write_data    (write_data),
      .write_address (write_address),
      .write_enable  (write_enable),
      .cursor_col    (cursor_col),
      .cursor_row    (cursor_row),
      .busy          (busy)
   );

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic void push(input int a, input int d);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
   endfunction

   function automatic void push_line(input int r);
      for (int i = 0; i < COLS; i++) push(r * COLS + i, 8'h20);
   endfunction

   function automatic void model(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         push(m_row * COLS + m_col, int'(b));
         m_col++;
         if (m_col == COLS) begin
            m_col = 0;
            m_row = (m_row + 1) % NROWS;
            push_line(m_row);
         end
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h0A) begin
         m_col = 0;
         m_row = (m_row + 1) % NROWS;
         push_line(m_row);
      end else if (b == 8'h08) begin
         if (m_col > 0) begin
            m_col--;
            push(m_row * COLS + m_col, 8'h20);
         end
      end else if (b == 8'h0C) begin
         m_col = 0;
         m_row = 0;
         for (int i = 0; i < SCREEN; i++) push(i, 8'h20);
      end
   endfunction

   always @(negedge clock) begin
      if (write_enable) begin
         if (exp_addr_q.size() == 0) begin
            check("unexpected write strobe", 1, 0);
         end else begin
            mon_a = exp_addr_q.pop_front();
            mon_d = exp_data_q.pop_front();
            check("write_address", int'(write_address), mon_a);
            check("write_data", int'(write_data), mon_d);
         end
      end
   end

   // All stimulus runs at posedge+1 so it never races the negedge monitor.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < LIM) begin
         @(posedge clock); #1;
         n++;
      end
      last_wait = n;
      if (n >= LIM) begin
         check("accept timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      model(b);
   endtask

   task automatic wait_ready(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = 0;
      while (!in_ready && cyc < LIM) begin
         if (busy) bcyc++;
         @(posedge clock); #1;
         cyc++;
      end
      if (cyc >= LIM) check("ready timeout", 0, 1);
   endtask

   task automatic check_cursor(input string name);
      check({name, " col"}, int'(cursor_col), m_col);
      check({name, " row"}, int'(cursor_row), m_row);
   endtask

   task automatic do_reset();
      int c, bc;
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      exp_addr_q.delete();
      exp_data_q.delete();
      m_col = 0;
      m_row = 0;
      reset = 1'b0;
      wait_ready(c, bc);
   endtask

   initial begin
      int cyc, bcyc, n, r;
      logic [7:0] b;

      repeat (2) begin @(posedge clock); #1; end
      check("reset write_enable", int'(write_enable), 0);
      check("reset write_data", int'(write_data), 0);
      check("reset write_address", int'(write_address), 0);
      check("reset cursor_col", int'(cursor_col), 0);
      check("reset cursor_row", int'(cursor_row), 0);
      check("reset busy", int'(busy), 0);
      check("reset in_ready", int'(in_ready), 0);
      reset = 1'b0;
      wait_ready(cyc, bcyc);
      check("ready after reset release", int'(cyc <= 2), 1);

      // single printable byte, write visible the cycle after acceptance
      send(8'h41);
      check("A write_enable", int'(write_enable), 1);
      check("A write_address", int'(write_address), 0);
      check("A write_data", int'(write_data), 8'h41);
      check("A cursor_col", int'(cursor_col), 1);

      // a full line then column wrap with a line clear
      do_reset();
      for (int i = 0; i < COLS; i++) send(8'h58);
      check("wrap in_ready low", int'(in_ready), 0);
      check("wrap cursor_col", int'(cursor_col), 0);
      check("wrap cursor_row", int'(cursor_row), 1);
      wait_ready(cyc, bcyc);
      check("line clear stall cycles", cyc, 100);
      check("line clear busy cycles", bcyc, 100);
      check_cursor("after wrap");

      // LF from the last row wraps to row 0 and clears it
      for (int i = 0; i < 73; i++) begin
         send(8'h0A);
         wait_ready(cyc, bcyc);
      end
      for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
      check("pre-LF cursor_row", int'(cursor_row), 74);
      check("pre-LF cursor_col", int'(cursor_col), 5);
      send(8'h0A);
      check("LF wrap cursor_row", int'(cursor_row), 0);
      check("LF wrap cursor_col", int'(cursor_col), 0);
      wait_ready(cyc, bcyc);
      check("LF wrap busy cycles", bcyc, 100);

      // backspace
      do_reset();
      send(8'h0A); wait_ready(cyc, bcyc);
      send(8'h0A); wait_ready(cyc, bcyc);
      send(8'h31); send(8'h32); send(8'h33);
      send(8'h08);
      check("BS write_enable", int'(write_enable), 1);
      check("BS write_address", int'(write_address), 202);
      check("BS write_data", int'(write_data), 8'h20);
      check("BS cursor_col", int'(cursor_col), 2);
      send(8'h08); send(8'h08);
      send(8'h08);
      check("BS at col 0 no write", int'(write_enable), 0);
      check_cursor("BS at col 0");

      // form feed: full-screen clear
      send(8'h0C);
      check_cursor("FF start");
      wait_ready(cyc, bcyc);
      check("FF stall cycles", cyc, SCREEN);
      check("FF busy cycles", bcyc, SCREEN);
      check_cursor("FF end");

      // reset in the middle of a screen clear
      send(8'h0C);
      n = 0;
      while (!(write_enable && write_address == 13'd3000) && n < LIM) begin
         @(posedge clock); #1;
         n++;
      end
      check("reached address 3000", int'(n < LIM), 1);
      reset = 1'b1;
      @(posedge clock); #1;
      check("abort write_enable", int'(write_enable), 0);
      check("abort busy", int'(busy), 0);
      check("abort cursor_col", int'(cursor_col), 0);
      check("abort cursor_row", int'(cursor_row), 0);
      exp_addr_q.delete();
      exp_data_q.delete();
      m_col = 0;
      m_row = 0;
      @(posedge clock); #1;
      reset = 1'b0;
      wait_ready(cyc, bcyc);
      check("ready after abort", int'(in_ready), 1);
      check("ready latency after abort", int'(cyc <= 2), 1);

      // ignored codes, back to back
      send(8'h68); send(8'h69);
      foreach (exp_addr_q[i]) ;
      b = 8'h07;
      for (int i = 0; i < 3; i++) begin
         send(b);
         check("ignored code accept wait", last_wait, 0);
         check("ignored code no write", int'(write_enable), 0);
         check("ignored code cursor_col", int'(cursor_col), 2);
         b = (i == 0) ? 8'h7F : 8'h85;
      end

      // randomized stream
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 75)      b = 8'($urandom_range(8'h20, 8'h7E));
         else if (r < 80) b = 8'h0A;
         else if (r < 85) b = 8'h0D;
         else if (r < 93) b = 8'h08;
         else begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h0C) b = 8'h1B;
         end
         send(b);
         repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end
      wait_ready(cyc, bcyc);
      repeat (3) begin @(posedge clock); #1; end
      check_cursor("random end");
      check("leftover expected writes", exp_addr_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
